// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled asynchronous serial receiver.
//
// Frames are a start bit, DATA_BITS data bits sent LSB first, an optional
// parity bit and STOP_BITS stop bits. The serial line is resynchronised to
// clk, and every bit is sampled once at its centre, counted in i_baud_rate
// ticks.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active low
//   i_baud_rate  oversample tick enable, one clk wide per tick
//   i_rx         asynchronous serial line, idle high
//   o_rx_done    one-clk pulse at the end of each accepted frame
//   o_data       last received word
//   o_parity_err parity mismatch flag for the last frame (0 when no parity)
//   o_frame_err  stop-bit error flag for the last frame
//   o_busy       receiver is not idle
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line idle, waiting for a low level on the synchronised line
// START     | qualify the start bit at its centre, else treat it as a glitch
// DATA      | sample DATA_BITS data bits at their centres, LSB first
// PARITY    | sample the parity bit and check it against the data
// STOP      | sample STOP_BITS stop bits and publish the frame
// WAIT_IDLE | framing error seen, hold off until the line returns high

module uart_rx_param #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_baud_rate,
   input  logic                 i_rx,
   output logic                 o_rx_done,
   output logic [DATA_BITS-1:0] o_data,
   output logic                 o_parity_err,
   output logic                 o_frame_err,
   output logic                 o_busy
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = 4;

   // Tick timer is a down-counter: the reload value sets the distance to the
   // next sample point, which is taken on the tick where the count is zero.
   localparam logic [TW-1:0] TC_HALF  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TC_FULL  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
   localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
   localparam logic          PAR_ODD   = (PARITY == 2);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_PARITY    = 3'd3;
   localparam logic [2:0] S_STOP      = 3'd4;
   localparam logic [2:0] S_WAIT_IDLE = 3'd5;

   logic                 rx_meta_q;
   logic                 rx_sync_q;
   logic [2:0]           state_q,    state_d;
   logic [TW-1:0]        tick_q,     tick_d;
   logic [BW-1:0]        bit_q,      bit_d;
   logic                 stop_q,     stop_d;
   logic [DATA_BITS-1:0] shift_q,    shift_d;
   logic                 perr_q,     perr_d;
   logic                 ferr_q,     ferr_d;
   logic [DATA_BITS-1:0] data_q,     data_d;
   logic                 perr_out_q, perr_out_d;
   logic                 ferr_out_q, ferr_out_d;
   logic                 done_q,     done_d;

   logic sample;
   logic ferr_now;

   assign sample   = i_baud_rate && (tick_q == '0);
   assign ferr_now = ferr_q | ~rx_sync_q;

   always_comb begin
      state_d    = state_q;
      tick_d     = tick_q;
      bit_d      = bit_q;
      stop_d     = stop_q;
      shift_d    = shift_q;
      perr_d     = perr_q;
      ferr_d     = ferr_q;
      data_d     = data_q;
      perr_out_d = perr_out_q;
      ferr_out_d = ferr_out_q;
      done_d     = 1'b0;

      // Shared timer step for the bit-timed states; sample points override it.
      if (i_baud_rate && (tick_q != '0) &&
          ((state_q == S_START) || (state_q == S_DATA) ||
           (state_q == S_PARITY) || (state_q == S_STOP))) begin
         tick_d = tick_q - TW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (!rx_sync_q) begin
               state_d = S_START;
               tick_d  = TC_HALF;
            end
         end

         S_START: begin
            if (sample) begin
               if (!rx_sync_q) begin
                  state_d = S_DATA;
                  tick_d  = TC_FULL;
                  bit_d   = BIT_LAST;
                  perr_d  = 1'b0;
                  ferr_d  = 1'b0;
               end else begin
                  // Line went back high before mid start bit: glitch.
                  state_d = S_IDLE;
               end
            end
         end

         S_DATA: begin
            if (sample) begin
               shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
               tick_d  = TC_FULL;
               if (bit_q == '0) begin
                  stop_d  = STOP_LAST;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q - BW'(1);
               end
            end
         end

         S_PARITY: begin
            if (sample) begin
               if (PARITY != 0) begin
                  perr_d = ((^shift_q) ^ rx_sync_q) != PAR_ODD;
               end
               tick_d  = TC_FULL;
               stop_d  = STOP_LAST;
               state_d = S_STOP;
            end
         end

         S_STOP: begin
            if (sample) begin
               tick_d = TC_FULL;
               ferr_d = ferr_now;
               if (stop_q == 1'b0) begin
                  data_d     = shift_q;
                  perr_out_d = perr_q;
                  ferr_out_d = ferr_now;
                  done_d     = 1'b1;
                  tick_d     = '0;
                  // A low stop bit may be a break; wait for the line to
                  // recover so it is not mistaken for another start bit.
                  state_d    = ferr_now ? S_WAIT_IDLE : S_IDLE;
               end else begin
                  stop_d = 1'b0;
               end
            end
         end

         S_WAIT_IDLE: begin
            if (rx_sync_q) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
            tick_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         state_q    <= S_IDLE;
         tick_q     <= '0;
         bit_q      <= '0;
         stop_q     <= 1'b0;
         shift_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         data_q     <= '0;
         perr_out_q <= 1'b0;
         ferr_out_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         rx_meta_q  <= i_rx;
         rx_sync_q  <= rx_meta_q;
         state_q    <= state_d;
         tick_q     <= tick_d;
         bit_q      <= bit_d;
         stop_q     <= stop_d;
         shift_q    <= shift_d;
         perr_q     <= perr_d;
         ferr_q     <= ferr_d;
         data_q     <= data_d;
         perr_out_q <= perr_out_d;
         ferr_out_q <= ferr_out_d;
         done_q     <= done_d;
      end
   end

   assign o_rx_done    = done_q;
   assign o_data       = data_q;
   assign o_parity_err = perr_out_q;
   assign o_frame_err  = ferr_out_q;
   assign o_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param. Two receivers: unit 0 is 8N1, unit 1 is
// 8 data bits, even parity, 2 stop bits. Frames are driven bit-by-bit by
// counting baud ticks; the expected word and flags for each frame are
// computed from the transmitted bits and queued, and a monitor per unit
// compares them whenever o_rx_done pulses.

module tb_uart_rx_param;

   localparam int OS = 16;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       baud = 1'b1;
   logic       rx0, rx1;
   logic       done0, done1, perr0, perr1, ferr0, ferr1, busy0, busy1;
   logic [7:0] data0, data1;

   int   checks = 0;
   int   errors = 0;
   int   tick_cnt = 0;
   bit   baud_rand = 1'b0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t last0 = '0;
   exp_t last1 = '0;

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst(rst), .i_baud_rate(baud), .i_rx(rx0),
      .o_rx_done(done0), .o_data(data0), .o_parity_err(perr0),
      .o_frame_err(ferr0), .o_busy(busy0));

   uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY(1), .STOP_BITS(2)) dut1 (
      .clk(clk), .rst(rst), .i_baud_rate(baud), .i_rx(rx1),
      .o_rx_done(done1), .o_data(data1), .o_parity_err(perr1),
      .o_frame_err(ferr1), .o_busy(busy1));

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      baud = baud_rand ? ($urandom_range(0, 2) == 0) : 1'b1;
   end

   initial forever begin
      @(posedge clk);
      if (baud) tick_cnt++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int par_of(input int u);
      return (u == 1) ? 1 : 0;
   endfunction

   function automatic int stop_of(input int u);
      return (u == 1) ? 2 : 1;
   endfunction

   function automatic logic busy_of(input int u);
      return (u == 0) ? busy0 : busy1;
   endfunction

   task automatic set_rx(input int u, input logic v);
      if (u == 0) rx0 = v;
      else        rx1 = v;
   endtask

   task automatic wait_ticks(input int n);
      int s;
      int g;
      s = tick_cnt;
      g = 0;
      while ((tick_cnt - s) < n && g < 20000) begin
         @(negedge clk);
         g++;
      end
      if (g >= 20000) chk("tick_wait_timeout", tick_cnt - s, n);
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Sends one frame on unit u and queues its expected result. stop_ok has
   // one bit per stop bit (1 = drive a good high stop bit). hold_low keeps
   // the line low for that many bit times after the stop bits.
   task automatic send_frame(input int u, input logic [7:0] d, input logic pbit,
                             input logic [1:0] stop_ok, input int gap, input int hold_low);
      exp_t e;
      int   ones;
      ones   = $countones(d) + int'(pbit);
      e.data = d;
      if (par_of(u) == 1)      e.perr = (ones % 2) != 0;
      else if (par_of(u) == 2) e.perr = (ones % 2) != 1;
      else                     e.perr = 1'b0;
      e.ferr = (stop_of(u) == 2) ? !(stop_ok[0] && stop_ok[1]) : !stop_ok[0];
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);

      set_rx(u, 1'b0);
      wait_ticks(OS);
      chk("busy_after_start", busy_of(u), 1);
      for (int i = 0; i < 8; i++) begin
         set_rx(u, d[i]);
         wait_ticks(OS);
         chk("busy_in_data", busy_of(u), 1);
      end
      if (par_of(u) != 0) begin
         set_rx(u, pbit);
         wait_ticks(OS);
      end
      for (int s = 0; s < stop_of(u); s++) begin
         set_rx(u, stop_ok[s]);
         wait_ticks(OS);
      end
      if (hold_low > 0) begin
         set_rx(u, 1'b0);
         wait_ticks(hold_low * OS);
         chk("busy_while_held_low", busy_of(u), 1);
      end
      set_rx(u, 1'b1);
      if (gap > 0) wait_ticks(gap * OS);
   endtask

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst) begin
         last0 = '0;
      end else if (done0) begin
         if (q0.size() == 0) begin
            chk("u0_unexpected_done", {31'b0, done0}, 0);
         end else begin
            e = q0.pop_front();
            chk("u0_data", {24'b0, data0}, {24'b0, e.data});
            chk("u0_parity_err", {31'b0, perr0}, {31'b0, e.perr});
            chk("u0_frame_err", {31'b0, ferr0}, {31'b0, e.ferr});
            last0 = e;
         end
      end
   end

   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst) begin
         last1 = '0;
      end else if (done1) begin
         if (q1.size() == 0) begin
            chk("u1_unexpected_done", {31'b0, done1}, 0);
         end else begin
            e = q1.pop_front();
            chk("u1_data", {24'b0, data1}, {24'b0, e.data});
            chk("u1_parity_err", {31'b0, perr1}, {31'b0, e.perr});
            chk("u1_frame_err", {31'b0, ferr1}, {31'b0, e.ferr});
            last1 = e;
         end
      end
   end

   initial begin
      #900000;
      errors++;
      $display("FAIL watchdog: simulation did not complete, q0=%0d q1=%0d pending", q0.size(), q1.size());
      $display("Result: errors=%0d of %0d checks", errors, checks + 1);
      $finish;
   end

   initial begin
      int         lat;
      int         g;
      logic [7:0] d;
      logic       pb;
      logic [1:0] so;
      int         gap;
      exp_t       hold;

      rst = 1'b0;
      rx0 = 1'b1;
      rx1 = 1'b1;
      wait_clks(4);
      chk("reset_state", {busy0, done0, perr0, ferr0, data0, busy1, done1, perr1, ferr1, data1}, 0);
      rst = 1'b1;
      wait_clks(4);
      chk("idle_not_busy", {30'b0, busy0, busy1}, 0);

      // 0xFD then 0xAF back to back, with latency of the first frame.
      lat = 0;
      fork
         begin
            send_frame(0, 8'hFD, 1'b0, 2'b11, 0, 0);
            send_frame(0, 8'hAF, 1'b0, 2'b11, 2, 0);
         end
         begin
            while (!done0 && lat < 300) begin
               @(negedge clk);
               lat++;
            end
            checks++;
            if (lat < 153 || lat > 155) begin
               errors++;
               $display("FAIL latency: got %0d clk, required 153..155", lat);
            end
         end
      join
      chk("idle_after_pair", {31'b0, busy0}, 0);

      // Four-clock low glitch on an idle line.
      hold = last0;
      rx0 = 1'b0;
      wait_clks(4);
      rx0 = 1'b1;
      g = 0;
      while (busy0 && g < 10) begin
         @(negedge clk);
         g++;
      end
      chk("glitch_busy_clears", {31'b0, busy0}, 0);
      wait_clks(20);
      chk("glitch_data_held", {24'b0, data0}, {24'b0, hold.data});
      chk("glitch_flags_held", {30'b0, perr0, ferr0}, {30'b0, hold.perr, hold.ferr});

      // Stop bit low, line held low for 40 bit times, then a good frame.
      send_frame(0, 8'h00, 1'b0, 2'b00, 0, 40);
      g = 0;
      while (busy0 && g < 10) begin
         @(negedge clk);
         g++;
      end
      chk("break_recovers", {31'b0, busy0}, 0);
      chk("break_flag_held", {31'b0, ferr0}, 1);
      send_frame(0, 8'h3C, 1'b0, 2'b11, 2, 0);

      // Even parity: 0x01 with a wrong then a right parity bit.
      send_frame(1, 8'h01, 1'b0, 2'b11, 1, 0);
      send_frame(1, 8'h01, 1'b1, 2'b11, 1, 0);

      // Randomised frames with jittery tick enable on both units.
      baud_rand = 1'b1;
      for (int k = 0; k < 24; k++) begin
         d   = 8'($urandom);
         pb  = ($countones(d) % 2 == 1);
         if ($urandom_range(0, 3) == 0) pb = ~pb;
         so  = 2'b11;
         if ($urandom_range(0, 4) == 0) so = 2'($urandom_range(0, 2));
         gap = $urandom_range(0, 2);
         if (so != 2'b11 && gap == 0) gap = 1;
         send_frame(k % 2, d, pb, so, gap, 0);
      end
      baud_rand = 1'b0;
      wait_clks(40);

      // Reset in the middle of data bit 4, then a clean 0x5A frame.
      d = 8'hA5;
      rx0 = 1'b0;
      wait_ticks(OS);
      for (int i = 0; i < 4; i++) begin
         rx0 = d[i];
         wait_ticks(OS);
      end
      rx0 = d[4];
      wait_ticks(OS / 2);
      chk("busy_before_reset", {31'b0, busy0}, 1);
      rst = 1'b0;
      #1;
      chk("reset_midframe_outputs", {busy0, done0, perr0, ferr0, data0, busy1, done1, perr1, ferr1, data1}, 0);
      rx0 = 1'b1;
      wait_clks(3);
      rst = 1'b1;
      wait_clks(40);
      chk("no_done_after_abort", {31'b0, busy0}, 0);
      send_frame(0, 8'h5A, 1'b0, 2'b11, 2, 0);

      wait_clks(40);
      chk("u0_queue_drained", q0.size(), 0);
      chk("u1_queue_drained", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
